// File: rtl/reg_pipe.sv
// reg_pipe: elastic register pipeline of DEPTH valid/ready stages, WIDTH bits wide.
// Adds synchronous flush and an output force override whose value stays on
// out_data after release until real data reaches the last stage.
//
// Handshake: a word transfers on a clock edge where valid and ready are both
// high. Valid does not depend on ready. in_ready depends combinationally on
// out_ready through the stage move chain, so a full pipe can accept a word in
// the same cycle that its last stage drains.
module reg_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    input  logic                         force_en,
    input  logic [WIDTH-1:0]             force_val,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int L     = DEPTH - 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Per-stage valid bits and data; sticky holds the last forced value
    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] sticky_val_q, sticky_val_d;

    logic [DEPTH-1:0] mv;
    logic             out_fire;
    logic             in_fire;

    // The output is masked while forcing and while the forced value is still sticky
    assign out_valid = v_q[L] & ~force_en & ~sticky_q;
    assign out_data  = force_en ? force_val : (sticky_q ? sticky_val_q : d_q[L]);
    assign out_fire  = out_valid & out_ready;

    // Stage i moves unless it and every stage after it are full with no drain
    always_comb begin
        logic blocked;
        blocked = ~out_fire;
        mv      = '0;
        for (int i = L; i >= 0; i--) begin
            blocked = blocked & v_q[i];
            mv[i]   = ~force_en & v_q[i] & ~blocked;
        end
    end

    assign in_ready = ~force_en & ~flush & (~v_q[0] | mv[0]);
    assign in_fire  = in_valid & in_ready;

    // Next state: flush beats force, force freezes the stages, otherwise shift
    always_comb begin
        v_d          = v_q;
        d_d          = d_q;
        sticky_d     = sticky_q;
        sticky_val_d = sticky_val_q;
        if (flush) begin
            v_d      = '0;
            sticky_d = 1'b0;
        end else if (force_en) begin
            sticky_d     = 1'b1;
            sticky_val_d = force_val;
        end else begin
            // Clear every mover first so a stage that is also reloaded ends valid
            v_d = v_q & ~mv;
            for (int i = 0; i < L; i++) begin
                if (mv[i]) begin
                    v_d[i+1] = 1'b1;
                    d_d[i+1] = d_q[i];
                end
            end
            if (in_fire) begin
                v_d[0] = 1'b1;
                d_d[0] = in_data;
            end
            // Real data in the last stage releases the sticky forced value
            if (v_d[L]) begin
                sticky_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q          <= '0;
            sticky_q     <= 1'b0;
            sticky_val_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= RST_VAL;
            end
        end else begin
            v_q          <= v_d;
            d_q          <= d_d;
            sticky_q     <= sticky_d;
            sticky_val_q <= sticky_val_d;
        end
    end

    // Occupancy is the number of valid stages
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v_q[i]);
        end
    end

endmodule
